// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: maps a valid/ready request stream onto single-port SRAM cycles and returns read data in order.
// Latency: sram_* driven in the accept cycle; read data valid READ_LAT+1 cycles after acceptance.
// Backpressure: reads stall once in-flight + buffered reads reach RSP_DEPTH; writes always flow. Zero-fill sweep: SRAM_PORT_CTRL_ZERO_INIT_EN.

module sram_port_ctrl_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_vld) begin
                mem_q[wr_ptr_q] <= push_dat;
                wr_ptr_q        <= ptr_next(wr_ptr_q);
            end
            if (pop_vld) rd_ptr_q <= ptr_next(rd_ptr_q);
            if (push_vld && !pop_vld)      count_q <= count_q + CW'(1);
            else if (!push_vld && pop_vld) count_q <= count_q - CW'(1);
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;
endmodule

module sram_port_ctrl #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NUM_WORDS  = 1024,
    parameter int unsigned READ_LAT   = 1,
    parameter int unsigned RSP_DEPTH  = 4,
    localparam int unsigned AW = $clog2(NUM_WORDS),
    localparam int unsigned BW = (DATA_WIDTH + 7) / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [AW-1:0]         req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [BW-1:0]         req_be_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  sram_req_o,
    output logic                  sram_we_o,
    output logic [AW-1:0]         sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    output logic [BW-1:0]         sram_be_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i,
    output logic                  init_done_o
);
    localparam int unsigned CW  = $clog2(RSP_DEPTH + 1);
    localparam int unsigned CRW = $clog2(RSP_DEPTH + READ_LAT + 1);

    logic                run;
    logic                init_active;
    logic                accept;
    logic                rd_acc;
    logic                rsp_pop;
    logic                credit_ok;
    logic [READ_LAT-1:0] rd_pipe_q;
    logic [CW-1:0]       fifo_cnt;
    logic [CRW-1:0]      credits_used;

`ifdef SRAM_PORT_CTRL_ZERO_INIT_EN
    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] init_addr_q, init_addr_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_INIT;
            init_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        if (state_q == ST_INIT) begin
            init_addr_d = init_addr_q + AW'(1);
            if (init_addr_q == AW'(NUM_WORDS - 1)) begin
                state_d     = ST_RUN;
                init_addr_d = '0;
            end
        end
    end

    assign run         = (state_q == ST_RUN);
    // Gate with reset so the sweep never strobes the macro while reset is held.
    assign init_active = (state_q == ST_INIT) && rst_ni;
`else
    assign run         = rst_ni;
    assign init_active = 1'b0;
`endif

    assign init_done_o = run;

    // Credits come from registered state only, so a pop frees its slot one cycle later.
    always_comb begin
        credits_used = CRW'(fifo_cnt);
        for (int i = 0; i < int'(READ_LAT); i++) begin
            credits_used = credits_used + CRW'(rd_pipe_q[i]);
        end
    end

    assign credit_ok   = (credits_used < CRW'(RSP_DEPTH));
    assign req_ready_o = run && (req_we_i || credit_ok);
    assign accept      = req_valid_i && req_ready_o;
    assign rd_acc      = accept && !req_we_i;

    always_comb begin
        sram_req_o   = accept;
        sram_we_o    = req_we_i;
        sram_addr_o  = req_addr_i;
        sram_wdata_o = req_wdata_i;
        sram_be_o    = req_be_i;
`ifdef SRAM_PORT_CTRL_ZERO_INIT_EN
        if (init_active) begin
            sram_req_o   = 1'b1;
            sram_we_o    = 1'b1;
            sram_addr_o  = init_addr_q;
            sram_wdata_o = '0;
            sram_be_o    = '1;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_pipe_q <= '0;
        end else begin
            rd_pipe_q[0] <= rd_acc;
            for (int i = 1; i < int'(READ_LAT); i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
        end
    end

    assign rsp_valid_o = (fifo_cnt != '0);
    assign rsp_pop     = rsp_valid_o && rsp_ready_i;

    sram_port_ctrl_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push_vld (rd_pipe_q[READ_LAT-1]),
        .push_dat (sram_rdata_i),
        .pop_vld  (rsp_pop),
        .head_dat (rsp_rdata_o),
        .count    (fifo_cnt)
    );
endmodule

// File: doc/sram_port_ctrl.md
# sram_port_ctrl

Initiator-side controller for the single-port synchronous `sram` wrapper. It turns a valid/ready request stream from cache or FPGA glue logic into SRAM port cycles, tracks in-flight reads across the fixed macro read latency, and buffers read data in a response FIFO so that downstream backpressure never loses data. An optional post-reset sweep zero-fills the array before the first request is accepted.

## Interface
- `DATA_WIDTH`, 64: word width in bits.
- `NUM_WORDS`, 1024: array depth; `AW = $clog2(NUM_WORDS)`.
- `READ_LAT`, 1: SRAM read latency in cycles. Legal values are 1 and 2; use 2 when the macro output registers are enabled.
- `RSP_DEPTH`, 4: number of response FIFO entries, which is also the read credit limit. Must be at least `READ_LAT+2`.

Ports:
- `clk_i` in, 1 bit: clock.
- `rst_ni` in, 1 bit: reset, asynchronous, active-low.
- `req_valid_i` in, 1 bit: request valid.
- `req_ready_o` out, 1 bit: request ready.
- `req_we_i` in, 1 bit: 1 = write, 0 = read.
- `req_addr_i` in, `AW` bits: word address.
- `req_wdata_i` in, `DATA_WIDTH` bits: write data.
- `req_be_i` in, `(DATA_WIDTH+7)/8` bits: byte enables.
- `rsp_valid_o` out, 1 bit: read data valid.
- `rsp_ready_i` in, 1 bit: consumer accepts read data.
- `rsp_rdata_o` out, `DATA_WIDTH` bits: read data.
- `sram_req_o`, `sram_we_o` out, 1 bit each: SRAM chip select and write enable.
- `sram_addr_o` out, `AW` bits; `sram_wdata_o` out, `DATA_WIDTH` bits; `sram_be_o` out, byte enables: SRAM address, write data and byte enables.
- `sram_rdata_i` in, `DATA_WIDTH` bits: SRAM read data.
- `init_done_o` out, 1 bit: controller is accepting requests.

## Operation
- **States:**
  - `INIT` exists only with the macro defined.
  - `RUN` is the normal operating state.
- **Request acceptance:**
  - A request is accepted when `req_valid_i && req_ready_o`. In the same cycle, `sram_*` carries the request combinationally.
  - When no request is accepted, `sram_req_o` = 0.
- **Writes:**
  - `req_ready_o` = 1 in `RUN`.
  - A write produces no response.
- **Reads:**
  - `credits_used` = (reads in flight) + (FIFO occupancy).
  - `req_ready_o` = (`credits_used` < `RSP_DEPTH`).
  - A pop in the same cycle does not free a credit until the next cycle.
- **In-flight tracking:**
  - A shift register `READ_LAT` stages deep carries a read-valid bit.
  - When a bit reaches the end, `sram_rdata_i` is pushed into the FIFO.
  - The FIFO can never overflow, and this is enforced by the credit rule.
- **FIFO:**
  - Circular buffer with wrap-around read and write pointers.
  - Push and pop in the same cycle leave occupancy unchanged.
  - `rsp_valid_o` = occupancy ≠ 0.
  - `rsp_rdata_o` = head entry, registered storage with no combinational path from `sram_rdata_i`.
  - Pop on `rsp_valid_o && rsp_ready_i`.
  - Responses are returned in request order.
- **Hold while stalled:** while `rsp_valid_o && !rsp_ready_i`, `rsp_rdata_o` holds stable.
- **Reset (including mid-operation):**
  - In-flight reads are dropped and the FIFO is emptied.
  - Reset values: `rsp_valid_o` = 0, `rsp_rdata_o` = 0, `sram_req_o` = 0.
  - The state machine enters `INIT` if configured, otherwise `RUN`.

## Timing
- **Read round trip:**
  - A read accepted in cycle N is pushed into the FIFO at the end of cycle N+`READ_LAT`.
  - `rsp_valid_o` is high from cycle N+`READ_LAT`+1.
- **Throughput:** one read per cycle is sustained while `rsp_ready_i` = 1, because `RSP_DEPTH` ≥ `READ_LAT+2`.
- **Read-after-write:** a write in cycle N followed by a read of the same address in cycle N+1 returns the new data.
- **Backpressure:** with `rsp_ready_i` = 0, exactly `RSP_DEPTH` reads are accepted, after which `req_ready_o` = 0 for read requests.
  - `req_ready_o` depends on `req_we_i` only through the credit term.
  - Writes remain accepted.

## Configuration
- Macro: `SRAM_PORT_CTRL_ZERO_INIT_EN`.
- **Defined:**
  - After reset the controller is in `INIT`, with `req_ready_o` = 0 and `init_done_o` = 0.
  - Each cycle it issues `sram_req_o` = 1, `sram_we_o` = 1, all byte enables = 1, `sram_wdata_o` = 0, with `sram_addr_o` counting 0 to `NUM_WORDS`-1.
  - After the write to the last address it enters `RUN` and sets `init_done_o` = 1.
  - Total: `NUM_WORDS` cycles.
  - Reset during `INIT` restarts the sweep at address 0.
- **Undefined:**
  - No `INIT` state.
  - `init_done_o` = 1 when `rst_ni` = 1, 0 during reset.
  - Uninitialised array contents are undefined.

## Test plan
- **Zero init:** macro defined, `NUM_WORDS` = 16, release reset → 16 consecutive write cycles, addresses 0..15, data 0; `init_done_o` rises in the following cycle; a read of address 7 returns 0.
- **Write then read:** write 0xDEADBEEF_CAFEF00D to address 3 with be = 0xFF, then write 0x11 with be = 0x01 → a read of address 3 returns 0xDEADBEEF_CAFEF011, with `rsp_valid_o` asserted 2 cycles after acceptance (`READ_LAT` = 1).
- **Backpressure:** `rsp_ready_i` = 0, `RSP_DEPTH` = 4, 6 back-to-back reads of addresses 0..5 → only 4 are accepted and `req_ready_o` = 0. Release `rsp_ready_i` → data for addresses 0..3 in order, then the remaining 2 reads are accepted.
- **Streaming:** `READ_LAT` = 2, `RSP_DEPTH` = 4, 32 back-to-back reads with `rsp_ready_i` = 1 → zero stall cycles, responses in order, first response in cycle N+3.
- **Random consumer stalls:** random `rsp_ready_i` and random mixed read/write traffic → every read is returned exactly once, in order, with the value matching the scoreboard, and the FIFO never overflows.
- **Reset mid-operation:** assert `rst_ni` = 0 with 2 reads in flight and 3 entries in the FIFO → `rsp_valid_o` = 0 immediately, and no stale response appears after reset is released.
